// File: rtl/eth_udp_pkg.sv
// Shared definitions for the UDP receive framer: FSM encoding and sizing defaults.
`timescale 1ns/1ps
package eth_udp_pkg;
  localparam int MAX_BYTES_DEF = 120;
  localparam int LEN_W_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_HOLD = 2'd2,
    ST_SKIP = 2'd3
  } rx_state_t;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; clr restarts it at 0 (or 1 when inc is also high), result registered.
// Sticks at all-ones; no flow control.
`timescale 1ns/1ps
module sat_counter
  import eth_udp_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [LEN_W-1:0] count
);
  logic [LEN_W-1:0] base;

  assign base = clr ? '0 : count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || inc) begin
      count <= (inc && (base != '1)) ? base + LEN_W'(1) : base;
    end
  end
endmodule

// File: rtl/udp_rx_framer.sv
// Packs one UDP payload into a wide frame word held until frame_ack; frame_valid rises 2 cycles after the last byte.
// No input backpressure: packets arriving while a frame is held are discarded whole and counted in drop_cnt.
`timescale 1ns/1ps
module udp_rx_framer
  import eth_udp_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF,
  parameter int LEN_W     = LEN_W_DEF
) (
  input  logic                   rgmii_clk,
  input  logic                   rst,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic [LEN_W-1:0]       rx_length,
  input  logic                   frame_ack,
  output logic                   frame_valid,
  output logic [MAX_BYTES*8-1:0] frame_data,
  output logic [LEN_W-1:0]       frame_bytes,
  output logic                   frame_trunc,
  output logic                   frame_len_err,
  output logic [LEN_W-1:0]       drop_cnt
);
  localparam int FW = MAX_BYTES * 8;

  rx_state_t        state, state_nxt;
  logic             prev_valid;
  logic [LEN_W-1:0] len_q;
  logic             start, take, drop_inc;

  always_ff @(posedge rgmii_clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // prev_valid resets high so a packet still in flight at reset release is skipped, not framed.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    take      = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (prev_valid) begin
            state_nxt = ST_SKIP;
          end else begin
            state_nxt = ST_RECV;
            start     = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (rx_valid) take = 1'b1;
        else          state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        drop_inc = rx_valid && !prev_valid;
        if (frame_ack) state_nxt = rx_valid ? ST_SKIP : ST_IDLE;
      end
      ST_SKIP: begin
        if (!rx_valid) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge rgmii_clk or posedge rst) begin
    if (rst) begin
      prev_valid  <= 1'b1;
      len_q       <= '0;
      frame_trunc <= 1'b0;
      frame_data  <= '0;
    end else begin
      prev_valid <= rx_valid;
      if (start) begin
        frame_data            <= '0;
        frame_data[FW-1 -: 8] <= rx_data;
        len_q                 <= rx_length;
        frame_trunc           <= 1'b0;
      end else if (take) begin
        // frame_bytes is the index of the incoming byte; beyond capacity it only counts.
        if (frame_bytes >= LEN_W'(MAX_BYTES)) frame_trunc <= 1'b1;
        for (int i = 0; i < MAX_BYTES; i++) begin
          if (frame_bytes == LEN_W'(i)) frame_data[FW-1-8*i -: 8] <= rx_data;
        end
      end
    end
  end

  sat_counter #(.LEN_W(LEN_W)) u_byte_cnt (
    .clk   (rgmii_clk),
    .rst   (rst),
    .clr   (start),
    .inc   (start || take),
    .count (frame_bytes)
  );

  sat_counter #(.LEN_W(LEN_W)) u_drop_cnt (
    .clk   (rgmii_clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

  assign frame_valid   = (state == ST_HOLD);
  assign frame_len_err = (frame_bytes != len_q);
endmodule

// File: tb/tb_udp_rx_framer.sv
// Randomized scoreboard bench for udp_rx_framer: a packet-level model predicts each held frame.
`timescale 1ns/1ps
module tb_udp_rx_framer;
  localparam int MAX_BYTES = 120;
  localparam int LEN_W     = 16;
  localparam int FW        = MAX_BYTES * 8;

  logic             rgmii_clk = 1'b0;
  logic             rst       = 1'b1;
  logic             rx_valid  = 1'b0;
  logic [7:0]       rx_data   = '0;
  logic [LEN_W-1:0] rx_length = '0;
  logic             frame_ack = 1'b0;
  logic             frame_valid;
  logic [FW-1:0]    frame_data;
  logic [LEN_W-1:0] frame_bytes;
  logic             frame_trunc;
  logic             frame_len_err;
  logic [LEN_W-1:0] drop_cnt;

  udp_rx_framer #(.MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)) dut (
    .rgmii_clk     (rgmii_clk),
    .rst           (rst),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .rx_length     (rx_length),
    .frame_ack     (frame_ack),
    .frame_valid   (frame_valid),
    .frame_data    (frame_data),
    .frame_bytes   (frame_bytes),
    .frame_trunc   (frame_trunc),
    .frame_len_err (frame_len_err),
    .drop_cnt      (drop_cnt)
  );

  always #4 rgmii_clk = ~rgmii_clk;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [FW-1:0] data;
    int            bytes;
    bit            trunc;
    bit            len_err;
    int            rise_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   exp_drop = 0;
  logic fv_prev  = 1'b0;

  always @(posedge rgmii_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    if (got !== exp) begin
      failures++;
      for (int i = 0; i < MAX_BYTES; i++)
        if (got[8*i +: 8] !== exp[8*i +: 8]) bad = i;
      $display("FAIL %s first differing byte %0d got=%h exp=%h", name, MAX_BYTES-1-bad,
               got[8*bad +: 8], exp[8*bad +: 8]);
    end
  endtask

  // Payload model: first MAX_BYTES bytes packed first-byte-first, then left-justified.
  function automatic exp_t model(input bq_t pkt, input int len, input int last_cyc);
    exp_t e;
    int   n;
    int   kept;
    n    = pkt.size();
    kept = (n < MAX_BYTES) ? n : MAX_BYTES;
    e.data = '0;
    for (int i = 0; i < kept; i++) e.data = (e.data << 8) | FW'(pkt[i]);
    e.data     = e.data << (8 * (MAX_BYTES - kept));
    e.bytes    = (n > 65535) ? 65535 : n;
    e.trunc    = (n > MAX_BYTES);
    e.len_err  = (e.bytes != len);
    e.rise_cyc = last_cyc + 2;
    return e;
  endfunction

  function automatic bq_t mk(input int n);
    bq_t q;
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic send(input bq_t pkt, input int len, input bit capture, input bit ack_first);
    foreach (pkt[i]) begin
      @(negedge rgmii_clk);
      rx_valid  = 1'b1;
      rx_data   = pkt[i];
      rx_length = LEN_W'(len);
      frame_ack = (i == 0) ? ack_first : 1'b0;
    end
    if (capture) begin
      last_exp = model(pkt, len, cyc);
      exp_q.push_back(last_exp);
    end
    @(negedge rgmii_clk);
    rx_valid  = 1'b0;
    rx_data   = '0;
    frame_ack = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int t;
    t = 0;
    while (frame_valid !== 1'b1 && t < 400) begin
      @(negedge rgmii_clk);
      t++;
    end
    chk({name, "_arrived"}, int'(frame_valid === 1'b1), 1);
  endtask

  task automatic do_ack();
    @(negedge rgmii_clk);
    frame_ack = 1'b1;
    @(negedge rgmii_clk);
    frame_ack = 1'b0;
    chk("ack_release_fv", int'(frame_valid), 0);
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_fv"}, int'(frame_valid), 0);
    chk_data({pfx, "_data"}, frame_data, '0);
    chk({pfx, "_bytes"}, int'(frame_bytes), 0);
    chk({pfx, "_trunc"}, int'(frame_trunc), 0);
    chk({pfx, "_len_err"}, int'(frame_len_err), 0);
    chk({pfx, "_drop"}, int'(drop_cnt), 0);
  endtask

  always @(negedge rgmii_clk) begin
    if (!rst && frame_valid && !fv_prev) begin
      chk("frame_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk_data("mon_data", frame_data, mon_e.data);
        chk("mon_bytes", int'(frame_bytes), mon_e.bytes);
        chk("mon_trunc", int'(frame_trunc), int'(mon_e.trunc));
        chk("mon_len_err", int'(frame_len_err), int'(mon_e.len_err));
        chk("mon_latency_cycle", cyc, mon_e.rise_cyc);
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t pkt;
    int  n, len, k;

    repeat (3) @(negedge rgmii_clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (3) @(negedge rgmii_clk);

    pkt = {8'h11, 8'h22, 8'h33, 8'h44};
    send(pkt, 4, 1'b1, 1'b0);
    wait_frame("four_byte");
    chk("four_byte_msbs", int'(frame_data[FW-1 -: 32]), 32'h11223344);
    chk("four_byte_len_err", int'(frame_len_err), 0);
    do_ack();

    send(mk(125), 125, 1'b1, 1'b0);
    wait_frame("trunc");
    chk("trunc_bytes", int'(frame_bytes), 125);
    chk("trunc_flag", int'(frame_trunc), 1);
    do_ack();

    send(mk(3), 5, 1'b1, 1'b0);
    wait_frame("short");
    chk("short_len_err", int'(frame_len_err), 1);
    chk("short_bytes", int'(frame_bytes), 3);
    do_ack();

    pkt = {8'hA5};
    send(pkt, 1, 1'b1, 1'b0);
    wait_frame("one_byte");
    chk("one_byte_msb", int'(frame_data[FW-1 -: 8]), 8'hA5);
    chk("one_byte_bytes", int'(frame_bytes), 1);
    do_ack();

    send(mk(40), 40, 1'b1, 1'b0);
    wait_frame("held");
    send(mk(5), 5, 1'b0, 1'b0);
    exp_drop++;
    send(mk(9), 9, 1'b0, 1'b0);
    exp_drop++;
    chk("held_drop_cnt", int'(drop_cnt), 2);
    chk_data("held_data_stable", frame_data, last_exp.data);
    chk("held_bytes_stable", int'(frame_bytes), 40);
    chk("held_fv", int'(frame_valid), 1);
    do_ack();

    send(mk(7), 7, 1'b1, 1'b0);
    wait_frame("ack_collide_first");
    send(mk(4), 4, 1'b0, 1'b1);
    exp_drop++;
    chk("ack_collide_fv", int'(frame_valid), 0);
    chk("ack_collide_drop", int'(drop_cnt), 3);
    pkt = {8'hAA, 8'hBB, 8'hCC};
    send(pkt, 3, 1'b1, 1'b0);
    wait_frame("after_skip");
    chk("after_skip_msbs", int'(frame_data[FW-1 -: 24]), 24'hAABBCC);
    do_ack();

    for (int it = 0; it < 20; it++) begin
      n   = $urandom_range(1, 130);
      len = ($urandom_range(0, 1) == 1) ? n : $urandom_range(1, 130);
      send(mk(n), len, 1'b1, 1'b0);
      wait_frame("rand");
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        send(mk($urandom_range(1, 6)), 3, 1'b0, 1'b0);
        exp_drop++;
      end
      if (k > 0) chk_data("rand_hold_data", frame_data, last_exp.data);
      if ($urandom_range(0, 3) == 0) begin
        send(mk($urandom_range(1, 5)), 2, 1'b0, 1'b1);
        exp_drop++;
        chk("rand_skip_fv", int'(frame_valid), 0);
      end else begin
        do_ack();
      end
      chk("rand_drop_cnt", int'(drop_cnt), exp_drop);
      repeat ($urandom_range(0, 2)) @(negedge rgmii_clk);
    end

    pkt = mk(10);
    for (int i = 0; i < 10; i++) begin
      @(negedge rgmii_clk);
      rx_valid  = 1'b1;
      rx_data   = pkt[i];
      rx_length = LEN_W'(10);
      if (i == 2) begin
        rst = 1'b1;
        #1;
        check_zero("mid_reset");
      end
      if (i == 3) rst = 1'b0;
    end
    @(negedge rgmii_clk);
    rx_valid = 1'b0;
    exp_drop = 0;
    repeat (5) @(negedge rgmii_clk);
    chk("post_reset_no_frame", int'(frame_valid), 0);
    chk("post_reset_drop", int'(drop_cnt), 0);

    send(mk(12), 12, 1'b1, 1'b0);
    wait_frame("recovered");
    do_ack();

    repeat (3) @(negedge rgmii_clk);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
